// File: rtl/bus_arbiter2.sv
// Two-master round-robin arbiter in front of the high mapper port.
// Serializes m0/m1 accesses, holds the downstream strobe, watchdog-aborts hangs.
module bus_arbiter2 #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_a,
    input  logic [31:0] m0_d,
    input  logic [3:0]  m0_web,
    input  logic        m0_rd,
    output logic [31:0] m0_spo,
    output logic        m0_ready,
    input  logic [31:0] m1_a,
    input  logic [31:0] m1_d,
    input  logic [3:0]  m1_web,
    input  logic        m1_rd,
    output logic [31:0] m1_spo,
    output logic        m1_ready,
    output logic [31:0] s_a,
    output logic [31:0] s_d,
    output logic [3:0]  s_web,
    output logic        s_rd,
    input  logic [31:0] s_spo,
    input  logic        s_ready,
    output logic        bus_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0
                                    : 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic        gnt;
    logic        last;
    logic [31:0] cap_a;
    logic [31:0] cap_d;
    logic [3:0]  cap_web;
    logic        cap_rd;
    logic [31:0] rdata;
    logic [31:0] cnt;
    logic [3:0]  web_q;
    logic        rd_q;
    logic        rdy0_q;
    logic        rdy1_q;
    logic        to_q;

    logic        req0;
    logic        req1;
    logic        pick;
    logic [31:0] sel_a;
    logic [31:0] sel_d;
    logic [3:0]  sel_web;
    logic        sel_rd;

    // Round-robin pick: a tie goes to the master not served last.
    always_comb begin
        req0    = m0_rd | (|m0_web);
        req1    = m1_rd | (|m1_web);
        pick    = (req0 & req1) ? ~last : req1;
        sel_a   = pick ? m1_a   : m0_a;
        sel_d   = pick ? m1_d   : m0_d;
        sel_web = pick ? m1_web : m0_web;
        sel_rd  = pick ? m1_rd  : m0_rd;
    end

    // Transaction FSM; every output is a flop so no input reaches an output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 1'b0;
            last    <= 1'b1;
            cap_a   <= '0;
            cap_d   <= '0;
            cap_web <= '0;
            cap_rd  <= 1'b0;
            rdata   <= '0;
            cnt     <= '0;
            web_q   <= '0;
            rd_q    <= 1'b0;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            rdy0_q <= 1'b0;
            rdy1_q <= 1'b0;
            to_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        cap_a   <= sel_a;
                        cap_d   <= sel_d;
                        cap_web <= sel_web;
                        cap_rd  <= sel_rd;
                        web_q   <= sel_web;
                        rd_q    <= sel_rd;
                        gnt     <= pick;
                        last    <= pick;
                        cnt     <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (s_ready || (TO_EN && cnt == TO_LAST)) begin
                        rdata  <= s_ready ? s_spo : TIMEOUT_DATA;
                        to_q   <= ~s_ready;
                        web_q  <= '0;
                        rd_q   <= 1'b0;
                        rdy0_q <= ~gnt;
                        rdy1_q <= gnt;
                        state  <= RESP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign s_a         = cap_a;
    assign s_d         = cap_d;
    assign s_web       = web_q;
    assign s_rd        = rd_q;
    assign m0_spo      = rdata;
    assign m1_spo      = rdata;
    assign m0_ready    = rdy0_q;
    assign m1_ready    = rdy1_q;
    assign bus_timeout = to_q;

    logic unused_ok;
    assign unused_ok = cap_rd ^ (|cap_web);

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed self-checking bench for bus_arbiter2 (watchdog set to 8 cycles).
// Inputs change 1 time unit after posedge; outputs are sampled at the same point.
module tb_bus_arbiter2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_a, m0_d, m0_spo;
    logic [3:0]  m0_web;
    logic        m0_rd, m0_ready;
    logic [31:0] m1_a, m1_d, m1_spo;
    logic [3:0]  m1_web;
    logic        m1_rd, m1_ready;
    logic [31:0] s_a, s_d, s_spo;
    logic [3:0]  s_web;
    logic        s_rd, s_ready;
    logic        bus_timeout;

    int n_chk = 0;
    int n_err = 0;

    bus_arbiter2 #(
        .TIMEOUT_CYCLES(8),
        .TIMEOUT_DATA  (32'hFFFFFFFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_a       (m0_a),
        .m0_d       (m0_d),
        .m0_web     (m0_web),
        .m0_rd      (m0_rd),
        .m0_spo     (m0_spo),
        .m0_ready   (m0_ready),
        .m1_a       (m1_a),
        .m1_d       (m1_d),
        .m1_web     (m1_web),
        .m1_rd      (m1_rd),
        .m1_spo     (m1_spo),
        .m1_ready   (m1_ready),
        .s_a        (s_a),
        .s_d        (s_d),
        .s_web      (s_web),
        .s_rd       (s_rd),
        .s_spo      (s_spo),
        .s_ready    (s_ready),
        .bus_timeout(bus_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m0_a = '0; m0_d = '0; m0_web = '0; m0_rd = 1'b0;
        m1_a = '0; m1_d = '0; m1_web = '0; m1_rd = 1'b0;
        s_spo = '0; s_ready = 1'b0;
        tick();
        tick();
        chk("rst_s_rd", 32'(s_rd), 0);
        chk("rst_s_web", 32'(s_web), 0);
        chk("rst_m0_ready", 32'(m0_ready), 0);
        chk("rst_m1_ready", 32'(m1_ready), 0);
        chk("rst_timeout", 32'(bus_timeout), 0);
        chk("rst_m0_spo", m0_spo, 0);
        chk("rst_s_a", s_a, 0);
        rst = 1'b0;
        tick();
        chk("idle_s_rd", 32'(s_rd), 0);

        // single read, 2 wait cycles, m0_a changes during BUSY
        m0_rd = 1'b1;
        m0_a  = 32'h100;
        tick();
        chk("rd_b1_s_rd", 32'(s_rd), 1);
        chk("rd_b1_s_a", s_a, 32'h100);
        chk("rd_b1_rdy", 32'(m0_ready), 0);
        m0_a = 32'h200;
        tick();
        chk("rd_b2_s_rd", 32'(s_rd), 1);
        chk("rd_b2_s_a", s_a, 32'h100);
        tick();
        chk("rd_b3_s_rd", 32'(s_rd), 1);
        chk("rd_b3_s_a", s_a, 32'h100);
        s_ready = 1'b1;
        s_spo   = 32'h12345678;
        tick();
        chk("rd_resp_rdy0", 32'(m0_ready), 1);
        chk("rd_resp_spo0", m0_spo, 32'h12345678);
        chk("rd_resp_rdy1", 32'(m1_ready), 0);
        chk("rd_resp_s_rd", 32'(s_rd), 0);
        s_ready = 1'b0;
        m0_rd   = 1'b0;
        tick();
        chk("rd_idle_rdy0", 32'(m0_ready), 0);

        // reset in the 2nd BUSY cycle of an m1 read
        m1_rd = 1'b1;
        m1_a  = 32'h20000000;
        tick();
        chk("rr_b1_s_rd", 32'(s_rd), 1);
        chk("rr_b1_s_a", s_a, 32'h20000000);
        tick();
        rst = 1'b1;
        tick();
        chk("rr_s_rd", 32'(s_rd), 0);
        chk("rr_s_web", 32'(s_web), 0);
        chk("rr_rdy1", 32'(m1_ready), 0);
        chk("rr_s_a", s_a, 0);
        rst    = 1'b0;
        m0_web = 4'hF;
        m0_d   = 32'hA5A5A5A5;
        m0_a   = 32'h10;

        // contention: tie after reset goes to m0, then alternate
        for (int t = 0; t < 4; t++) begin
            tick();
            if (t % 2 == 0) begin
                chk("ct_m0_s_web", 32'(s_web), 32'hF);
                chk("ct_m0_s_rd", 32'(s_rd), 0);
                chk("ct_m0_s_a", s_a, 32'h10);
                chk("ct_m0_s_d", s_d, 32'hA5A5A5A5);
            end else begin
                chk("ct_m1_s_rd", 32'(s_rd), 1);
                chk("ct_m1_s_web", 32'(s_web), 0);
                chk("ct_m1_s_a", s_a, 32'h20000000);
            end
            s_ready = 1'b1;
            s_spo   = 32'hCAFE0000 + 32'(t);
            tick();
            chk("ct_rdy0", 32'(m0_ready), (t % 2 == 0) ? 1 : 0);
            chk("ct_rdy1", 32'(m1_ready), (t % 2 == 1) ? 1 : 0);
            chk("ct_spo", (t % 2 == 0) ? m0_spo : m1_spo,
                32'hCAFE0000 + 32'(t));
            s_ready = 1'b0;
            if (t == 3) begin
                m0_web = '0;
                m1_rd  = 1'b0;
            end
            tick();
            chk("ct_idle_s_rd", 32'(s_rd), 0);
        end

        // watchdog: 8 BUSY cycles then abort
        m1_rd = 1'b1;
        m1_a  = 32'h300;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("to_busy_s_rd", 32'(s_rd), 1);
            chk("to_busy_to", 32'(bus_timeout), 0);
        end
        tick();
        chk("to_pulse", 32'(bus_timeout), 1);
        chk("to_rdy1", 32'(m1_ready), 1);
        chk("to_spo1", m1_spo, 32'hFFFFFFFF);
        chk("to_s_rd", 32'(s_rd), 0);
        m1_rd = 1'b0;
        tick();
        chk("to_after", 32'(bus_timeout), 0);
        chk("to_after_rdy", 32'(m1_ready), 0);

        // completion exactly on the expiry cycle beats the watchdog
        m0_rd = 1'b1;
        m0_a  = 32'h400;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("ex_busy_s_rd", 32'(s_rd), 1);
        end
        s_ready = 1'b1;
        s_spo   = 32'h5A5A0001;
        tick();
        chk("ex_rdy0", 32'(m0_ready), 1);
        chk("ex_spo0", m0_spo, 32'h5A5A0001);
        chk("ex_to", 32'(bus_timeout), 0);
        s_ready = 1'b0;
        m0_rd   = 1'b0;
        tick();
        chk("ex_idle", 32'(m0_ready), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
